// File: rtl/mem_access_unit.sv
// mem_access_unit
//   M-stage load/store unit. Decodes the access region, steers byte lanes,
//   extends load data, checks alignment and runs a multi-cycle handshake to
//   the device bridge. Data memory is zero-wait; the device window stalls
//   the pipeline until dev_ack arrives or the timeout expires.
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   req_valid, mem_op,
//   addr, wdata, flush    : M-stage instruction (mem_op 0..7 = LB LBU LH LHU LW SB SH SW)
//   dm_we, dm_be,
//   dm_wdata, dm_rdata    : data memory port (async read)
//   dev_req, dev_we,
//   dev_addr, dev_be,
//   dev_wdata, dev_rdata,
//   dev_ack               : device bridge handshake (request side registered)
//   stall                 : pipeline freeze
//   rdata, rdata_valid    : extended load result to W stage
//   exc_adel, exc_ades,
//   exc_bus               : load/store alignment error, unmapped or timeout
module mem_access_unit #(
  parameter logic [31:0] DM_BASE   = 32'h0000_0000,
  parameter logic [31:0] DM_LIMIT  = 32'h0000_2FFF,
  parameter logic [31:0] DEV_BASE  = 32'h0000_7F00,
  parameter logic [31:0] DEV_LIMIT = 32'h0000_7FFF,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  output logic        dev_req,
  output logic        dev_we,
  output logic [31:0] dev_addr,
  output logic [3:0]  dev_be,
  output logic [31:0] dev_wdata,
  input  logic [31:0] dev_rdata,
  input  logic        dev_ack,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        exc_bus
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    op_q;
  logic [31:0]   cap_data;

  logic        is_store;
  logic        misaligned;
  logic        in_dm;
  logic        in_dev;
  logic [3:0]  lane_be;
  logic [31:0] lane_data;
  logic        issue;
  logic        go_dev;

  // Sign/zero extension of the addressed byte or half of a read word.
  function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (op)
      3'd0:    load_ext = {{24{b[7]}}, b};
      3'd1:    load_ext = {24'd0, b};
      3'd2:    load_ext = {{16{h[15]}}, h};
      3'd3:    load_ext = {16'd0, h};
      default: load_ext = w;
    endcase
  endfunction

  // Offset-based range test avoids a constant-true compare when a base is 0.
  assign in_dm  = (addr - DM_BASE)  <= (DM_LIMIT - DM_BASE);
  assign in_dev = (addr - DEV_BASE) <= (DEV_LIMIT - DEV_BASE);
  assign is_store = (mem_op >= 3'd5);

  always_comb begin
    misaligned = 1'b0;
    lane_be    = 4'b1111;
    lane_data  = wdata;
    case (mem_op)
      3'd0, 3'd1, 3'd5: begin
        lane_be   = 4'b0001 << addr[1:0];
        lane_data = {4{wdata[7:0]}};
      end
      3'd2, 3'd3, 3'd6: begin
        misaligned = addr[0];
        lane_be    = addr[1] ? 4'b1100 : 4'b0011;
        lane_data  = {2{wdata[15:0]}};
      end
      default: misaligned = (addr[1:0] != 2'b00);
    endcase
  end

  assign issue  = (state == S_IDLE) && req_valid && !flush;
  assign go_dev = issue && !misaligned && in_dev;

  always_comb begin
    dm_we       = 1'b0;
    dm_be       = '0;
    dm_wdata    = '0;
    stall       = 1'b0;
    rdata       = '0;
    rdata_valid = 1'b0;
    exc_adel    = 1'b0;
    exc_ades    = 1'b0;
    exc_bus     = 1'b0;
    case (state)
      S_IDLE: begin
        if (issue) begin
          // Alignment is checked first so it takes precedence over unmapped.
          if (misaligned) begin
            exc_adel = !is_store;
            exc_ades = is_store;
          end else if (in_dm) begin
            if (is_store) begin
              dm_we    = 1'b1;
              dm_be    = lane_be;
              dm_wdata = lane_data;
            end else begin
              rdata       = load_ext(mem_op, addr[1:0], dm_rdata);
              rdata_valid = 1'b1;
            end
          end else if (in_dev) begin
            stall = 1'b1;
          end else begin
            exc_bus = 1'b1;
          end
        end
      end
      S_REQ:  stall = 1'b1;
      S_DONE: begin
        if (op_q < 3'd5) begin
          rdata       = load_ext(op_q, dev_addr[1:0], cap_data);
          rdata_valid = 1'b1;
        end
      end
      default: exc_bus = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op_q      <= '0;
      cap_data  <= '0;
      dev_req   <= 1'b0;
      dev_we    <= 1'b0;
      dev_addr  <= '0;
      dev_be    <= '0;
      dev_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go_dev) begin
            state     <= S_REQ;
            cnt       <= '0;
            op_q      <= mem_op;
            dev_req   <= 1'b1;
            dev_we    <= is_store;
            dev_addr  <= addr;
            dev_be    <= lane_be;
            dev_wdata <= is_store ? lane_data : '0;
          end
        end
        S_REQ: begin
          // flush is not looked at here: an issued device access must finish.
          if (dev_ack) begin
            cap_data <= dev_rdata;
            dev_req  <= 1'b0;
            dev_we   <= 1'b0;
            state    <= S_DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            dev_req <= 1'b0;
            dev_we  <= 1'b0;
            state   <= S_ERR;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
